alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//   Shares the single EX-stage ALU between two requesters: port 0 (pipeline EX issue)
//   and port 1 (auxiliary unit, e.g. branch-target/compare helper). Arbitrates valid/ready
//   requests, drives the ALU operands/control combinationally, and captures the ALU
//   result and zero flag in a one-entry response register tagged with the winner's ID.
// PARAMETERS
//   WIDTH        32  operand/result width; must match the ALU data width
//   FIXED_PRIO   0   0 = round-robin between ports; 1 = port 0 always wins
//   STARVE_LIMIT 8   FIXED_PRIO=1 only: consecutive cycles port 1 may wait before a forced grant (1..255)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   req0_valid in   1      port 0 request present
//   req0_ready out  1      port 0 request accepted this cycle
//   req0_a     in   WIDTH  port 0 operand A
//   req0_b     in   WIDTH  port 0 operand B
//   req0_ctrl  in   3      port 0 ALU control code
//   req1_valid/req1_ready/req1_a/req1_b/req1_ctrl  same as port 0, for port 1
//   alu_a      out  WIDTH  to ALU Read_data_1
//   alu_b      out  WIDTH  to ALU Data_2
//   alu_ctrl   out  3      to ALU ALU_control
//   alu_result in   WIDTH  from ALU Result
//   alu_zero   in   1      from ALU Zero_flag
//   rsp_valid  out  1      response register holds a result
//   rsp_ready  in   1      consumer takes response this cycle
//   rsp_id     out  1      port that issued the response
//   rsp_data   out  WIDTH  captured ALU result
//   rsp_zero   out  1      captured zero flag
//   rsp_err    out  1      request used an undefined ctrl code (not 0,1,2,6,7)
// BEHAVIOUR
//   - Reset (async, rst_n=0): rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, rsp_err=0,
//     RR pointer=port 0 preferred, starve counter=0; reqX_ready=0 while rst_n=0.
//   - Response register states: EMPTY (rsp_valid=0) / FULL (rsp_valid=1).
//     can_issue = EMPTY or (FULL and rsp_ready). Grant only when can_issue.
//   - Grant (combinational, same cycle): one of reqX_ready high only if reqX_valid and
//     can_issue; never both. Single valid requester always wins.
//   - Both valid, FIXED_PRIO=0: grant port named by RR pointer; pointer flips to the
//     other port after every grant (either port). FIXED_PRIO=1: port 0 wins unless starve
//     counter == STARVE_LIMIT, then port 1 wins.
//   - Starve counter (FIXED_PRIO=1): +1 each cycle req1_valid=1 and req1 not granted,
//     saturates at STARVE_LIMIT; cleared on port-1 grant or req1_valid=0.
//   - ALU drive: alu_a/alu_b/alu_ctrl = granted port's fields; when no grant, drive port 0
//     fields (no state effect). ALU is combinational; result sampled in grant cycle.
//   - Latency: accepted at edge N -> rsp_valid=1 with data after edge N (1 cycle).
//   - Capture on grant: rsp_data<=alu_result, rsp_zero<=alu_zero, rsp_id<=port,
//     rsp_err<=(ctrl in {3,4,5}); FULL. Undefined codes still pass ALU output (0) through.
//   - FULL and rsp_ready=1 with no grant -> EMPTY. FULL, rsp_ready=0 -> all outputs held
//     stable, both reqX_ready=0 (back-pressure).
//   - Simultaneous drain+grant: new result replaces old in same edge, rsp_valid stays 1.
//   - Requester fields must be stable while valid and not ready; arbiter does not latch them.
//   - Reset mid-operation: in-flight response discarded, no ready asserted until rst_n=1.
// TESTING
//   1 req0 a=5 b=3 ctrl=2, rsp_ready=1 -> req0_ready same cycle; next cycle rsp_data=8, id=0, zero=0, err=0
//   2 both valid, FIXED_PRIO=0, from reset -> grants 0,1,0,1 on successive cycles; rsp_id follows
//   3 req1 a=7 b=7 ctrl=6 -> rsp_data=0, rsp_zero=1, id=1; ctrl=7 a=3 b=9 -> rsp_data=1
//   4 rsp_ready=0 with FULL, both valid 5 cycles -> no ready, rsp_* stable; raise rsp_ready -> drain+grant same edge
//   5 FIXED_PRIO=1, STARVE_LIMIT=3, both valid continuously -> 0,0,0,1,0,0,0,1 grant pattern
//   6 req0 ctrl=4 a=F0 b=0F -> rsp_data=0, rsp_zero=1, rsp_err=1; rst_n pulse while FULL -> rsp_valid=0 immediately

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two-port arbiter in front of one combinational EX-stage ALU. The winning result
// is captured in a single-entry response register tagged with the winner's port id.
module alu_share_arbiter #(
  parameter int WIDTH        = 32,
  parameter bit FIXED_PRIO   = 1'b0,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err
);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic       can_issue, pick1, gnt0, gnt1;
  logic       rr_ptr;
  logic [7:0] starve_cnt;

  // rst_n gates the grant so no ready escapes while reset is held
  assign can_issue = rst_n && (!rsp_valid || rsp_ready);
  assign pick1     = FIXED_PRIO ? (starve_cnt == STARVE_MAX) : rr_ptr;
  assign gnt1      = can_issue && req1_valid && (!req0_valid || pick1);
  assign gnt0      = can_issue && req0_valid && !gnt1;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Port 0 fields are the idle default; harmless since nothing is captured
  assign alu_a    = gnt1 ? req1_a    : req0_a;
  assign alu_b    = gnt1 ? req1_b    : req0_b;
  assign alu_ctrl = gnt1 ? req1_ctrl : req0_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      rr_ptr     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (gnt0 || gnt1) begin
        rsp_valid <= 1'b1;
        rsp_id    <= gnt1;
        rsp_data  <= alu_result;
        rsp_zero  <= alu_zero;
        rsp_err   <= alu_ctrl inside {3'd3, 3'd4, 3'd5};
        rr_ptr    <= gnt0;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (!req1_valid || gnt1)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: round-robin instance plus a fixed-priority (limit 3) instance,
// each with a behavioural ALU and a scoreboard queue drained by a response monitor.
module tb_alu_share_arbiter;
  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        zero;
    logic        err;
  } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t q_rr[$];
  exp_t q_fp[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid = 0, req1_valid = 0, rsp_ready = 1;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [2:0]  req0_ctrl = 0, req1_ctrl = 0;
  logic        req0_ready, req1_ready;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic        alu_zero;
  logic        rsp_valid, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_data;

  logic        fp_v0 = 0, fp_v1 = 0;
  logic        fp_r0, fp_r1;
  logic [31:0] fp_alu_a, fp_alu_b, fp_alu_result;
  logic [2:0]  fp_alu_ctrl;
  logic        fp_alu_zero;
  logic        fp_rsp_valid, fp_rsp_id, fp_rsp_zero, fp_rsp_err;
  logic [31:0] fp_rsp_data;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] c);
    case (c)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd6: return a - b;
      3'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result    = alu_f(alu_a, alu_b, alu_ctrl);
  assign alu_zero      = (alu_result == 32'd0);
  assign fp_alu_result = alu_f(fp_alu_a, fp_alu_b, fp_alu_ctrl);
  assign fp_alu_zero   = (fp_alu_result == 32'd0);

  alu_share_arbiter #(.WIDTH(32), .FIXED_PRIO(1'b0), .STARVE_LIMIT(8)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  alu_share_arbiter #(.WIDTH(32), .FIXED_PRIO(1'b1), .STARVE_LIMIT(3)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(fp_v0), .req0_ready(fp_r0), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl),
    .req1_valid(fp_v1), .req1_ready(fp_r1), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_ctrl(fp_alu_ctrl),
    .alu_result(fp_alu_result), .alu_zero(fp_alu_zero),
    .rsp_valid(fp_rsp_valid), .rsp_ready(1'b1), .rsp_id(fp_rsp_id),
    .rsp_data(fp_rsp_data), .rsp_zero(fp_rsp_zero), .rsp_err(fp_rsp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Monitors: one response consumed per cycle whenever valid && ready
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      exp_t act, exp;
      act = '{id: rsp_id, data: rsp_data, zero: rsp_zero, err: rsp_err};
      checks++;
      if (q_rr.size() == 0) begin
        errors++;
        $display("FAIL rr_unexpected_rsp got %h", act);
      end else begin
        exp = q_rr.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL rr_rsp got id/data/zero/err %h want %h", act, exp);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && fp_rsp_valid) begin
      exp_t act, exp;
      act = '{id: fp_rsp_id, data: fp_rsp_data, zero: fp_rsp_zero, err: fp_rsp_err};
      checks++;
      if (q_fp.size() == 0) begin
        errors++;
        $display("FAIL fp_unexpected_rsp got %h", act);
      end else begin
        exp = q_fp.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL fp_rsp got id/data/zero/err %h want %h", act, exp);
        end
      end
    end
  end

  // One cycle: drive at posedge+1, check combinational readies, cross the edge
  task automatic cyc(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                     input logic [2:0] c0, input logic v1, input logic [31:0] a1,
                     input logic [31:0] b1, input logic [2:0] c1, input logic rr,
                     input logic e0, input logic e1, input string nm);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
    rsp_ready = rr;
    #1;
    chk({nm, "_ready0"}, {31'd0, req0_ready}, {31'd0, e0});
    chk({nm, "_ready1"}, {31'd0, req1_ready}, {31'd0, e1});
    @(posedge clk); #1;
  endtask

  task automatic idle(input string nm);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, nm);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    #1;
    chk("rst_ready0", {31'd0, req0_ready}, 0);
    chk("rst_ready1", {31'd0, req1_ready}, 0);
    chk("rst_valid", {31'd0, rsp_valid}, 0);
    chk("rst_id", {31'd0, rsp_id}, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_zero", {31'd0, rsp_zero}, 0);
    chk("rst_err", {31'd0, rsp_err}, 0);
    @(posedge clk); @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();

    // 1: 5+3
    q_rr.push_back('{0, 32'd8, 1'b0, 1'b0});
    cyc(1, 5, 3, 2, 0, 0, 0, 0, 1, 1, 0, "t1");
    idle("t1_idle");

    // 2: round robin from reset; port0 10-4=6, port1 1&2=0
    do_reset();
    for (int i = 0; i < 2; i++) begin
      q_rr.push_back('{0, 32'd6, 1'b0, 1'b0});
      cyc(1, 10, 4, 6, 1, 1, 2, 0, 1, 1, 0, "t2_p0");
      q_rr.push_back('{1, 32'd0, 1'b1, 1'b0});
      cyc(1, 10, 4, 6, 1, 1, 2, 0, 1, 0, 1, "t2_p1");
    end
    idle("t2_idle");

    // 3: sub equal -> zero; slt 3<9 -> 1
    q_rr.push_back('{1, 32'd0, 1'b1, 1'b0});
    cyc(0, 0, 0, 0, 1, 7, 7, 6, 1, 0, 1, "t3_sub");
    q_rr.push_back('{1, 32'd1, 1'b0, 1'b0});
    cyc(0, 0, 0, 0, 1, 3, 9, 7, 1, 0, 1, "t3_slt");
    idle("t3_idle");

    // 4: fill with 2|2=2 while consumer stalls, then back-pressure, then drain+grant
    q_rr.push_back('{0, 32'd2, 1'b0, 1'b0});
    cyc(1, 2, 2, 1, 0, 0, 0, 0, 0, 1, 0, "t4_fill");
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 1, 2, 1, 12, 10, 0, 0, 0, 0, "t4_stall");
      chk("t4_hold_valid", {31'd0, rsp_valid}, 1);
      chk("t4_hold_data", rsp_data, 2);
      chk("t4_hold_id", {31'd0, rsp_id}, 0);
    end
    q_rr.push_back('{1, 32'd8, 1'b0, 1'b0});
    cyc(1, 1, 1, 2, 1, 12, 10, 0, 1, 0, 1, "t4_drain");
    chk("t4_still_valid", {31'd0, rsp_valid}, 1);
    idle("t4_idle");

    // 5: fixed priority, starve limit 3; port0 4-1=3, port1 5+1=6
    req0_a = 4; req0_b = 1; req0_ctrl = 6;
    req1_a = 5; req1_b = 1; req1_ctrl = 2;
    for (int i = 0; i < 8; i++) begin
      if ((i % 4) == 3) q_fp.push_back('{1, 32'd6, 1'b0, 1'b0});
      else              q_fp.push_back('{0, 32'd3, 1'b0, 1'b0});
    end
    fp_v0 = 1; fp_v1 = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t5_fp_ready1", {31'd0, fp_r1}, ((i % 4) == 3) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    fp_v0 = 0; fp_v1 = 0;
    idle("t5_idle");

    // 6: undefined ctrl 4, then reset while FULL
    q_rr.push_back('{0, 32'd0, 1'b1, 1'b1});
    cyc(1, 32'hF0, 32'h0F, 4, 0, 0, 0, 0, 1, 1, 0, "t6_err");
    idle("t6_idle");
    cyc(1, 1, 1, 2, 0, 0, 0, 0, 0, 1, 0, "t6_fill");
    chk("t6_full", {31'd0, rsp_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_clear", {31'd0, rsp_valid}, 0);
    chk("t6_rst_ready0", {31'd0, req0_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0_valid = 0;
    idle("t6_post");
    chk("t6_post_valid", {31'd0, rsp_valid}, 0);

    chk("rr_queue_empty", q_rr.size(), 0);
    chk("fp_queue_empty", q_fp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
